// File: rtl/ds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ds_pkg
//  Description : Shared widths, default variance limits, FSM state encoding
//                and the variance clamp helper for the sigma-delta
//                background-subtraction pixel pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
package ds_pkg;

    localparam int PIX_W    = 8;    // colour / luma / M / V width
    localparam int LUMA_W   = 10;   // R + 2G + B intermediate width
    localparam int VMIN_DEF = 2;
    localparam int VMAX_DEF = 255;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_CALC    = 2'd1,
        S_OUT     = 2'd2
    } state_t;

    // Saturate a widened variance into [lo, hi] and narrow it to PIX_W bits.
    function automatic logic [PIX_W-1:0] clamp_var(
        input logic [LUMA_W-1:0] v,
        input logic [LUMA_W-1:0] lo,
        input logic [LUMA_W-1:0] hi
    );
        logic [LUMA_W-1:0] t;
        t = v;
        if (t < lo) t = lo;
        if (t > hi) t = hi;
        return t[PIX_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ds_bg_ram.sv
`default_nettype none
// ============================================================================
//  Module      : ds_bg_ram
//  Description : Single-port background RAM holding one {M,V} word per pixel.
//                Registered read with one cycle latency; a write in the same
//                cycle as a read returns the old contents (no write-first).
//  Revision    : 1.0  initial release
//
//  Ports
//    clk      in   clock, rising edge
//    i_we     in   write enable
//    i_re     in   read enable (loads o_rdata on the next edge)
//    i_addr   in   AW  word address
//    i_wdata  in   DW  write data
//    o_rdata  out  DW  registered read data
// ============================================================================
module ds_bg_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ds_pixel_update.sv
`default_nettype none
// ============================================================================
//  Module      : ds_pixel_update
//  Description : Sigma-delta background model update. Collects an R,G,B byte
//                triple from an upstream FIFO, converts it to luma, updates
//                the per-pixel mean/variance stored in ds_bg_ram and emits a
//                one-bit foreground mask through a valid/ready handshake.
//  Revision    : 1.0  initial release
//
//  Configuration macro
//    DS_VAR_CLAMP_EN  defined   : updated variance clamped to [VMIN,VMAX]
//                     undefined : updated variance only saturates to [1,255]
//
//  Ports
//    clk         in   sole clock, rising edge
//    reset       in   synchronous active-high reset
//    fifo_empty  in   upstream byte FIFO empty
//    fifo_data   in   8  upstream byte (R, G, B order)
//    fifo_rd_en  out  byte pop, consumes fifo_data this cycle
//    mask        out  foreground flag for the current pixel
//    mask_valid  out  mask / mask_last valid
//    mask_ready  in   downstream accepts mask
//    mask_last   out  current pixel is the last of the frame
// ============================================================================
module ds_pixel_update
    import ds_pkg::*;
#(
    parameter int NPIX  = 256,
    parameter int N_AMP = 2,
    parameter int VMIN  = VMIN_DEF,
    parameter int VMAX  = VMAX_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [PIX_W-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             mask,
    output logic             mask_valid,
    input  logic             mask_ready,
    output logic             mask_last
);

    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

`ifdef DS_VAR_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    localparam logic [LUMA_W-1:0] V_LO = CLAMP_EN ? LUMA_W'(VMIN) : LUMA_W'(1);
    localparam logic [LUMA_W-1:0] V_HI = CLAMP_EN ? LUMA_W'(VMAX) : LUMA_W'(255);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_byte_cnt;
    logic [PIX_W-1:0]   r_r;
    logic [PIX_W-1:0]   r_g;
    logic [PIX_W-1:0]   r_b;
    logic [IDX_W-1:0]   r_index;
    logic               r_init;
    logic               r_mask;
    logic               r_last;

    logic               w_ram_we;
    logic               w_ram_re;
    logic               w_hs;
    logic [2*PIX_W-1:0] w_rd;
    logic [2*PIX_W-1:0] w_wdata;

    logic [LUMA_W-1:0]  w_luma;
    logic [PIX_W-1:0]   w_y;
    logic [PIX_W-1:0]   w_m;
    logic [PIX_W-1:0]   w_v;
    logic [PIX_W-1:0]   w_mn;
    logic [PIX_W-1:0]   w_d;
    logic [LUMA_W-1:0]  w_amp;
    logic [LUMA_W-1:0]  w_v_ext;
    logic [LUMA_W-1:0]  w_v_step;
    logic [PIX_W-1:0]   w_vn;
    logic               w_last_pix;

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        fifo_rd_en = 1'b0;
        w_ram_we   = 1'b0;
        w_ram_re   = 1'b0;
        w_hs       = 1'b0;
        case (r_state)
            S_COLLECT: begin
                fifo_rd_en = !fifo_empty;
                // The final byte also launches the background read so that
                // {M,V} is available as soon as CALC starts.
                if (!fifo_empty && (r_byte_cnt == 2'd2)) begin
                    w_ram_re = 1'b1;
                    w_next   = S_CALC;
                end
            end
            S_CALC: begin
                w_ram_we = 1'b1;
                w_next   = S_OUT;
            end
            S_OUT: begin
                if (mask_ready) begin
                    w_hs   = 1'b1;
                    w_next = S_COLLECT;
                end
            end
            default: w_next = S_COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // Luma and sigma-delta update datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_luma  = {2'b00, r_r} + {1'b0, r_g, 1'b0} + {2'b00, r_b};
        w_y     = PIX_W'(w_luma >> 2);
        w_m     = w_rd[2*PIX_W-1:PIX_W];
        w_v     = w_rd[PIX_W-1:0];

        // Mean steps by one toward Y; the comparisons rule out wrap.
        if (w_m < w_y) begin
            w_mn = w_m + 8'd1;
        end else if (w_m > w_y) begin
            w_mn = w_m - 8'd1;
        end else begin
            w_mn = w_m;
        end

        w_d     = (w_y >= w_mn) ? (w_y - w_mn) : (w_mn - w_y);
        w_amp   = LUMA_W'(N_AMP) * {2'b00, w_d};
        w_v_ext = {2'b00, w_v};

        // V > amp implies V >= 2 here, so the decrement cannot underflow.
        w_v_step = w_v_ext;
        if (w_d != '0) begin
            if (w_v_ext < w_amp) begin
                w_v_step = w_v_ext + 10'd1;
            end else if (w_v_ext > w_amp) begin
                w_v_step = w_v_ext - 10'd1;
            end
        end

        w_vn       = clamp_var(w_v_step, V_LO, V_HI);
        w_wdata    = r_init ? {w_y, PIX_W'(VMIN)} : {w_mn, w_vn};
        w_last_pix = (r_index == IDX_W'(NPIX - 1));
    end

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_COLLECT;
            r_byte_cnt <= 2'd0;
            r_r        <= '0;
            r_g        <= '0;
            r_b        <= '0;
            r_index    <= '0;
            r_init     <= 1'b1;
            r_mask     <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_state <= w_next;

            if (fifo_rd_en) begin
                case (r_byte_cnt)
                    2'd0: begin
                        r_r        <= fifo_data;
                        r_byte_cnt <= 2'd1;
                    end
                    2'd1: begin
                        r_g        <= fifo_data;
                        r_byte_cnt <= 2'd2;
                    end
                    default: begin
                        r_b        <= fifo_data;
                        r_byte_cnt <= 2'd0;
                    end
                endcase
            end

            if (r_state == S_CALC) begin
                r_mask <= r_init ? 1'b0 : (w_d > w_vn);
                r_last <= w_last_pix;
            end

            if (w_hs) begin
                if (w_last_pix) begin
                    r_index <= '0;
                    r_init  <= 1'b0;
                end else begin
                    r_index <= r_index + 1'b1;
                end
            end
        end
    end

    assign mask       = r_mask;
    assign mask_last  = r_last;
    assign mask_valid = (r_state == S_OUT);

    ds_bg_ram #(
        .DEPTH (NPIX),
        .AW    (IDX_W),
        .DW    (2*PIX_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (r_index),
        .i_wdata (w_wdata),
        .o_rdata (w_rd)
    );

endmodule
`default_nettype wire

// File: tb/tb_ds_pixel_update.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ds_pixel_update
//  Description : Table-driven bench for ds_pixel_update (NPIX=4, N_AMP=2,
//                VMIN=2, default build) with a mask/mask_last scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ds_pixel_update;

    localparam int NPIX = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       mask;
    logic       mask_valid;
    logic       mask_ready;
    logic       mask_last;

    ds_pixel_update #(
        .NPIX  (NPIX),
        .N_AMP (2),
        .VMIN  (2),
        .VMAX  (255)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .mask       (mask),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready),
        .mask_last  (mask_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        int          gap_b;     // empty cycles before the B byte
        int          rdy_dly;   // cycles mask_ready stays low in OUT
        logic        exp_mask;
        logic        exp_last;
        int          exp_idx;
        logic [15:0] exp_ram;   // {M,V} after the update
    } vec_t;

    vec_t       vecs [15];
    logic [1:0] sb_q [$];
    int         n_vec  = 0;
    int         n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted mask is compared against the oldest pushed
    // expectation.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!reset && mask_valid && mask_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL sb_unexpected: got mask=%0b last=%0b expected no output", mask, mask_last);
            end else begin
                e = sb_q.pop_front();
                check("sb_mask_last", {30'd0, mask, mask_last}, {30'd0, e});
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic push_byte(input logic [7:0] b, input int gap);
        int t;
        fifo_empty = 1'b1;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            check("rd_en_gap", {31'd0, fifo_rd_en}, 32'd0);
            @(posedge clk); #1;
        end
        fifo_data  = b;
        fifo_empty = 1'b0;
        t = 0;
        @(negedge clk);
        while (!fifo_rd_en && t < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            n_vec++;
            n_miss++;
            $display("FAIL rd_en_timeout: got rd_en=0 expected rd_en=1 within 20 cycles");
        end
        @(posedge clk); #1;
        fifo_empty = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v, output int b_cyc);
        logic hold;
        push_byte(v.r, 0);
        push_byte(v.g, 0);
        push_byte(v.b, v.gap_b);
        b_cyc = cyc;
        sb_q.push_back({v.exp_mask, v.exp_last});
        // Keep upstream non-empty: nothing may be popped outside COLLECT.
        fifo_empty = 1'b0;
        fifo_data  = 8'hEE;
        mask_ready = (v.rdy_dly == 0);
        @(negedge clk);
        check("valid_in_calc", {31'd0, mask_valid}, 32'd0);
        check("rd_en_calc", {31'd0, fifo_rd_en}, 32'd0);
        @(negedge clk);
        check("valid_2cyc", {31'd0, mask_valid}, 32'd1);
        check("rd_en_out", {31'd0, fifo_rd_en}, 32'd0);
        check("ram_word", {16'd0, dut.u_ram.r_mem[v.exp_idx]}, {16'd0, v.exp_ram});
        hold = mask;
        if (v.rdy_dly > 0) begin
            for (int i = 1; i < v.rdy_dly; i++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("hold_valid", {31'd0, mask_valid}, 32'd1);
                check("hold_mask", {31'd0, mask}, {31'd0, hold});
                check("hold_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            end
            @(posedge clk); #1;
            mask_ready = 1'b1;
            fifo_empty = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        mask_ready = 1'b0;
        fifo_empty = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cur_b;
        int prev_b;
        //           r      g      b     gap dly  m     l    idx ram
        vecs[0]  = '{8'h40, 8'h40, 8'h40, 0, 0, 1'b0, 1'b0, 0, 16'h4002};
        vecs[1]  = '{8'h10, 8'h20, 8'h30, 3, 0, 1'b0, 1'b0, 1, 16'h2002};
        vecs[2]  = '{8'hFF, 8'hFF, 8'hFF, 0, 5, 1'b0, 1'b0, 2, 16'hFF02};
        vecs[3]  = '{8'h00, 8'h00, 8'h00, 0, 0, 1'b0, 1'b1, 3, 16'h0002};
        vecs[4]  = '{8'h50, 8'h50, 8'h50, 0, 0, 1'b1, 1'b0, 0, 16'h4103};
        vecs[5]  = '{8'h00, 8'h00, 8'h00, 0, 2, 1'b1, 1'b0, 1, 16'h1F03};
        vecs[6]  = '{8'hFF, 8'hFF, 8'hFF, 0, 0, 1'b0, 1'b0, 2, 16'hFF02};
        vecs[7]  = '{8'h00, 8'h00, 8'h00, 1, 0, 1'b0, 1'b1, 3, 16'h0002};
        vecs[8]  = '{8'h41, 8'h41, 8'h41, 0, 0, 1'b0, 1'b0, 0, 16'h4103};
        vecs[9]  = '{8'h20, 8'h20, 8'h20, 0, 0, 1'b0, 1'b0, 1, 16'h2003};
        vecs[10] = '{8'h7E, 8'h7E, 8'h7E, 0, 0, 1'b1, 1'b0, 2, 16'hFE03};
        vecs[11] = '{8'h01, 8'h01, 8'h01, 0, 0, 1'b0, 1'b1, 3, 16'h0102};
        vecs[12] = '{8'h43, 8'h43, 8'h43, 0, 0, 1'b0, 1'b0, 0, 16'h4202};
        vecs[13] = '{8'h11, 8'h22, 8'h33, 0, 0, 1'b0, 1'b0, 0, 16'h2202};
        vecs[14] = '{8'h99, 8'h99, 8'h99, 0, 0, 1'b0, 1'b0, 1, 16'h9902};

        reset      = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        mask_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", {31'd0, mask_valid}, 32'd0);
        check("rst_mask", {31'd0, mask}, 32'd0);
        check("rst_last", {31'd0, mask_last}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        prev_b = 0;
        for (int i = 0; i < 13; i++) begin
            apply_vec(vecs[i], cur_b);
            if (i > 0 && vecs[i].gap_b == 0 && vecs[i-1].rdy_dly == 0)
                check("pixel_period", cur_b - prev_b, 32'd5);
            prev_b = cur_b;
        end

        // Reset with two bytes of pixel 1 already collected.
        push_byte(8'h12, 0);
        push_byte(8'h34, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_valid", {31'd0, mask_valid}, 32'd0);
        check("midrst_mask", {31'd0, mask}, 32'd0);
        check("midrst_last", {31'd0, mask_last}, 32'd0);
        check("midrst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        @(posedge clk); #1;

        apply_vec(vecs[13], cur_b);
        apply_vec(vecs[14], cur_b);

        repeat (2) @(posedge clk);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
